// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rxd, arms an external baud generator on a
// start edge and assembles one frame per arm, sampling on the mid-bit bps_clk enable.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 bps_clk,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rxd_d_q;
    logic                 rxd_s;
    logic                 fall;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 bps_start_q, bps_start_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 busy_q, busy_d;

    assign rxd_s = sync_q[1];
    // Edge detect runs one flop past the synchroniser so it never sees a metastable value.
    assign fall  = rxd_d_q & ~rxd_s;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        bps_start_d  = bps_start_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d     = START;
                    bps_start_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            START: begin
                if (bps_clk) begin
                    if (!rxd_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        // Glitch rather than a real start bit: disarm without reporting.
                        state_d     = IDLE;
                        bps_start_d = 1'b0;
                        busy_d      = 1'b0;
                    end
                end
            end
            DATA: begin
                if (bps_clk) begin
                    sr_d      = {rxd_s, sr_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bps_clk) begin
                    par_d   = rxd_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bps_clk) begin
                    // Leaving mid stop bit gives the next start edge half a bit of slack.
                    rx_data_d    = sr_q;
                    rx_valid_d   = 1'b1;
                    frame_err_d  = ~rxd_s;
                    parity_err_d = (PARITY_EN != 0) & (^sr_q ^ par_q ^ (PARITY_ODD != 0));
                    bps_start_d  = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                bps_start_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            rxd_d_q      <= 1'b1;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            bps_start_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], rxd};
            rxd_d_q      <= rxd_s;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            par_q        <= par_d;
            bps_start_q  <= bps_start_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bps_start  = bps_start_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;

endmodule
